// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Divides an 8-bit product-width dividend by a 4-bit operand-width divisor.
// Optional feature macro: SEQ_DIVIDER_DBZ_EN (divide-by-zero short-circuit + dbz flag).
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      request a division (ignored while busy)
//   dividend   8-bit numerator, captured on an accepted start
//   divisor    4-bit denominator, captured on an accepted start
//   quotient   8-bit result, updated on entry to DONE
//   remainder  4-bit result, updated on entry to DONE
//   busy       high while a division is in progress
//   done       one-cycle pulse when results become valid
//   dbz        divide-by-zero flag (tied low without SEQ_DIVIDER_DBZ_EN)
module seq_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       dbz
);

  localparam int unsigned DW = 8;  // dividend / quotient width
  localparam int unsigned VW = 4;  // divisor / remainder width
  localparam int unsigned RW = 5;  // partial remainder width after shift
  localparam int unsigned CW = 3;  // step counter width

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] dvd_q;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [VW-1:0] dvs_q;
  logic [VW-1:0] rem_q;   // partial remainder between steps; always < divisor so 4 bits hold it
  logic [CW-1:0] cnt_q;

  logic [RW-1:0] r_shift;
  logic [VW-1:0] r_next;
  logic          q_bit;

  // One restoring step: shift in next dividend bit, subtract divisor if it fits.
  always_comb begin
    r_shift = {rem_q, dvd_q[DW-1]};
    q_bit   = (r_shift >= {1'b0, dvs_q});
    r_next  = q_bit ? VW'(r_shift - RW'(dvs_q)) : r_shift[VW-1:0];
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            cnt_q <= '0;
            dbz   <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
`ifdef SEQ_DIVIDER_DBZ_EN
          if (dvs_q == '0) begin
            // Zero divisor: skip the shift-subtract loop and flag it.
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            dbz       <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
          end else
`endif
          begin
            dvd_q <= {dvd_q[DW-2:0], q_bit};
            rem_q <= r_next;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(DW - 1)) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              quotient  <= {dvd_q[DW-2:0], q_bit};
              remainder <= r_next;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider. The driver pushes the
// expected result (with expected done cycle and busy length) on each accepted
// start; a monitor pops and compares whenever done is seen.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       dbz;

  seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  q;
    logic [3:0]  r;
    logic        z;
    int unsigned done_cyc;
    int unsigned blen;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc    = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned brun   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: track busy run length, pop and compare on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      brun++;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 q=%0h r=%0h, required no pending division (cycle %0d)",
                   quotient, remainder, cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient",   32'(quotient),  32'(e.q));
          chk("remainder",  32'(remainder), 32'(e.r));
          chk("dbz",        32'(dbz),       32'(e.z));
          chk("done_cycle", cyc,            e.done_cyc);
          chk("busy_len",   brun,           e.blen);
        end
      end
      brun = 0;
    end
  end

  task automatic push(input logic [7:0] q, input logic [3:0] r, input logic z,
                      input int unsigned lat, input int unsigned blen);
    exp_t e;
    e.q        = q;
    e.r        = r;
    e.z        = z;
    e.done_cyc = cyc + lat;
    e.blen     = blen;
    sb.push_back(e);
  endtask

  // Issue one start pulse and record the expected response.
  task automatic issue(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] q, input logic [3:0] r, input logic z);
    int unsigned lat;
    int unsigned blen;
    lat  = 9;
    blen = 8;
`ifdef SEQ_DIVIDER_DBZ_EN
    if (b == 4'h0) begin
      lat  = 2;
      blen = 1;
    end
`endif
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    push(q, r, z, lat, blen);
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending results, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("reset_quotient",  32'(quotient),  32'h0);
    chk("reset_remainder", 32'(remainder), 32'h0);
    chk("reset_busy",      32'(busy),      32'h0);
    chk("reset_done",      32'(done),      32'h0);
    chk("reset_dbz",       32'(dbz),       32'h0);
    rst = 1'b0;

    // Basic and boundary operands.
    issue(8'd200, 4'd7,  8'd28,  4'd4,  1'b0); wait_idle();
    issue(8'd255, 4'd1,  8'd255, 4'd0,  1'b0); wait_idle();
    issue(8'd13,  4'd14, 8'd0,   4'd13, 1'b0); wait_idle();
    issue(8'd225, 4'd15, 8'd15,  4'd0,  1'b0); wait_idle();

    // Multiplier round-trip: (a*b)/b == a, remainder 0.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(8'(a * b), 4'(b), 8'(a), 4'd0, 1'b0);
        wait_idle();
      end
    end

    // start pulsed mid-RUN with different operands is ignored.
    issue(8'd100, 4'd9, 8'd11, 4'd1, 1'b0);
    repeat (3) @(negedge clk);
    dividend = 8'd50;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_idle();

    // start held high through the done cycle: back-to-back acceptance.
    @(negedge clk);
    dividend = 8'd255;
    divisor  = 4'd1;
    start    = 1'b1;
    push(8'd255, 4'd0, 1'b0, 9, 8);
    repeat (4) @(negedge clk);
    dividend = 8'd7;
    divisor  = 4'd2;
    repeat (5) @(negedge clk);
    dividend = 8'd13;
    divisor  = 4'd14;
    push(8'd0, 4'd13, 1'b0, 9, 8);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset on the 4th RUN edge aborts; no done may follow.
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    wait_idle();
    @(negedge clk);
    dividend = 8'd99;
    divisor  = 4'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy",      32'(busy),      32'h0);
    chk("abort_done",      32'(done),      32'h0);
    chk("abort_quotient",  32'(quotient),  32'h0);
    chk("abort_remainder", 32'(remainder), 32'h0);
    rst = 1'b0;
    repeat (15) @(negedge clk);

    // Divide by zero, then a normal division clears dbz.
`ifdef SEQ_DIVIDER_DBZ_EN
    issue(8'd200, 4'd0, 8'h00, 4'h0, 1'b1); wait_idle();
`else
    issue(8'd200, 4'd0, 8'hFF, 4'h8, 1'b0); wait_idle();
`endif
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0); wait_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
